// File: rtl/tnn_popcount_accum.sv
// Accumulates signed (pos - neg) popcount differences over CHUNKS beats and emits a ternary activation.
// Optional macro TNN_ACCUM_SAT_EN: clamp each accumulation instead of wrapping.
module tnn_popcount_accum #(
  parameter int PC_W   = 5,
  parameter int CHUNKS = 4,
  parameter int ACC_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PC_W-1:0]         pc_pos,
  input  logic [PC_W-1:0]         pc_neg,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_act,
  output logic signed [ACC_W-1:0] out_sum
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic [1:0]              act_q, act_d;
  logic                    valid_q, valid_d;

  logic                    accept_s;
  logic                    last_s;
  logic signed [PC_W:0]    diff_s;
  logic signed [ACC_W-1:0] delta_s;
  logic signed [ACC_W-1:0] acc_next_s;

  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
`ifdef TNN_ACCUM_SAT_EN
    logic [ACC_W:0] wide;
    wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      acc_add = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_add = $signed(wide[ACC_W-1:0]);
    end
`else
    acc_add = a + b;
`endif
  endfunction

  assign in_ready = (state_q == ST_ACC) | ((state_q == ST_DONE) & out_ready);
  assign accept_s = in_valid & in_ready;
  assign last_s   = (cnt_q == LAST_CNT);

  // Zero-extended operands keep the difference exact before sign extension to ACC_W.
  assign diff_s     = $signed({1'b0, pc_pos}) - $signed({1'b0, pc_neg});
  assign delta_s    = ACC_W'(diff_s);
  assign acc_next_s = acc_add(acc_q, delta_s);

  // Next-state, accumulator, counter and result computation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    act_d   = act_q;
    if (accept_s) begin
      if (last_s) begin
        sum_d   = acc_next_s;
        if (acc_next_s > $signed(thr_hi)) begin
          act_d = 2'b01;
        end else if (acc_next_s < $signed(thr_lo)) begin
          act_d = 2'b11;
        end else begin
          act_d = 2'b00;
        end
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_DONE;
      end else begin
        acc_d   = acc_next_s;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_ACC;
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d = ST_ACC;
    end else begin
      state_d = state_q;
    end
    valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      act_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      act_q   <= act_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_act   = act_q;
  assign out_sum   = sum_q;

endmodule
